// File: rtl/async_fifo.sv
// async_fifo: single-clock FIFO buffer, DEPTH words of DWIDTH bits.
// Read and write pointers carry an extra wrap bit so that full and empty
// can be told apart; this pointer/flag arrangement carries over unchanged
// to a later dual-clock variant.
// Optional feature: define ASYNC_FIFO_ERR_FLAGS_EN to add sticky
// overflow/underflow outputs (push attempted while full / pop attempted
// while empty).
module async_fifo #(
    parameter int DEPTH    = 16,
    parameter int PTRWIDTH = 4,
    parameter int DWIDTH   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DWIDTH-1:0] wdata,
    output logic              full,
    input  logic              pop,
    output logic [DWIDTH-1:0] rdata,
    output logic              empty
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    ,
    output logic              overflow,
    output logic              underflow
`endif
);

    localparam logic [PTRWIDTH:0] PTR_ONE = 1;

    // Storage is never reset; only the pointers define what is valid.
    logic [DWIDTH-1:0] mem [DEPTH];

    logic [PTRWIDTH:0]   wptr_q, wptr_d;
    logic [PTRWIDTH:0]   rptr_q, rptr_d;
    logic [DWIDTH-1:0]   rdata_q;
    logic                push_ok;
    logic                pop_ok;
    logic [PTRWIDTH-1:0] waddr;
    logic [PTRWIDTH-1:0] raddr;

    assign waddr = wptr_q[PTRWIDTH-1:0];
    assign raddr = rptr_q[PTRWIDTH-1:0];

    // Flags decode straight from the registered pointers.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[PTRWIDTH] != rptr_q[PTRWIDTH]) && (waddr == raddr);

    // Accept decisions use the flags as they stand before the edge.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign rdata = rdata_q;

    // Next-state pointers: advance by one per accepted transfer, wrapping mod 2*DEPTH.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_ok) begin
            wptr_d = wptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rptr_d = rptr_q + PTR_ONE;
        end
    end

    // Pointer registers; reset discards every stored word.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port; rdata holds unless a pop is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (pop_ok) begin
            rdata_q <= mem[raddr];
        end
    end

`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;

    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    // Sticky error flags: latch any push into a full FIFO or pop from an empty one.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_q  | (push && full);
            underflow_q <= underflow_q | (pop && empty);
        end
    end
`endif

endmodule

// File: tb/tb_async_fifo.sv
// Testbench for async_fifo: a short table of hand-computed vectors, directed
// corner-case sequences, then randomized traffic checked against a
// queue-based reference model.
module tb_async_fifo;

    logic       clk;
    logic       reset;
    logic       push;
    logic [7:0] wdata;
    logic       full;
    logic       pop;
    logic [7:0] rdata;
    logic       empty;
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    logic       overflow;
    logic       underflow;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: occupancy as a queue, plus last read value and sticky errors.
    logic [7:0] mq[$];
    logic [7:0] m_rdata;
    bit         m_ovf;
    bit         m_unf;

    async_fifo #(
        .DEPTH(16),
        .PTRWIDTH(4),
        .DWIDTH(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .push(push),
        .wdata(wdata),
        .full(full),
        .pop(pop),
        .rdata(rdata),
        .empty(empty)
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
        ,
        .overflow(overflow),
        .underflow(underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Apply one cycle of stimulus, advance the model, sample 1 time unit after the edge.
    task automatic step(input logic rst, input logic p, input logic q, input logic [7:0] d);
        bit do_push;
        bit do_pop;
        reset = rst;
        push  = p;
        pop   = q;
        wdata = d;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_rdata = 8'h00;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
        end else begin
            do_push = p && (mq.size() < 16);
            do_pop  = q && (mq.size() > 0);
            if (p && mq.size() == 16) m_ovf = 1'b1;
            if (q && mq.size() == 0)  m_unf = 1'b1;
            if (do_pop)  m_rdata = mq.pop_front();
            if (do_push) mq.push_back(d);
        end
        #1;
    endtask

    task automatic check_model(input string name);
        check({name, "_empty"}, {31'd0, empty}, {31'd0, (mq.size() == 0)});
        check({name, "_full"},  {31'd0, full},  {31'd0, (mq.size() == 16)});
        check({name, "_rdata"}, {24'd0, rdata}, {24'd0, m_rdata});
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
        check({name, "_ovf"}, {31'd0, overflow},  {31'd0, m_ovf});
        check({name, "_unf"}, {31'd0, underflow}, {31'd0, m_unf});
`endif
    endtask

    typedef struct {
        logic       push;
        logic       pop;
        logic [7:0] wdata;
        logic       exp_empty;
        logic       exp_full;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];

    initial begin
        // Hand-computed vectors, applied from an empty FIFO with rdata=0.
        vecs[0] = '{1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 8'h00};
        vecs[2] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h11};
        vecs[3] = '{1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 8'h22};
        vecs[4] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h33};
        vecs[5] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h33};
        vecs[6] = '{1'b1, 1'b1, 8'h44, 1'b0, 1'b0, 8'h33};
        vecs[7] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h44};

        m_rdata = 8'h00;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;

        // Reset for two cycles with push held high: nothing may be stored.
        step(1'b1, 1'b1, 1'b0, 8'hAA);
        step(1'b1, 1'b1, 1'b0, 8'hAA);
        check("reset_empty", {31'd0, empty}, 32'd1);
        check("reset_full",  {31'd0, full},  32'd0);
        check("reset_rdata", {24'd0, rdata}, 32'd0);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        check("reset_nothing_stored", {31'd0, empty}, 32'd1);
        check("reset_pop_rdata", {24'd0, rdata}, 32'd0);
        check_model("reset");

        // Table-driven vectors.
        for (int i = 0; i < 8; i++) begin
            step(1'b0, vecs[i].push, vecs[i].pop, vecs[i].wdata);
            check($sformatf("vec%0d_empty", i), {31'd0, empty}, {31'd0, vecs[i].exp_empty});
            check($sformatf("vec%0d_full", i),  {31'd0, full},  {31'd0, vecs[i].exp_full});
            check($sformatf("vec%0d_rdata", i), {24'd0, rdata}, {24'd0, vecs[i].exp_rdata});
        end

        // Fill 0x01..0x10: full only after the 16th push.
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'(i + 1));
            check($sformatf("fill%0d_full", i), {31'd0, full}, {31'd0, (i == 15)});
            check($sformatf("fill%0d_empty", i), {31'd0, empty}, 32'd0);
        end
        step(1'b0, 1'b1, 1'b0, 8'hFF);
        check("overfill_full", {31'd0, full}, 32'd1);
        check_model("overfill");

        // Drain: data returns 0x01..0x10 one cycle after each pop.
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'h00);
            check($sformatf("drain%0d_rdata", i), {24'd0, rdata}, 32'(i + 1));
        end
        check("drain_empty", {31'd0, empty}, 32'd1);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        check("underpop_rdata", {24'd0, rdata}, 32'h10);
        check_model("underpop");

        // Wrap-around: 10 in, 10 out, then 16 more across the pointer wrap.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h60 + i));
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'h00);
            check($sformatf("wrapA%0d_rdata", i), {24'd0, rdata}, 32'(8'h60 + i));
        end
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 8'(8'hA0 + i));
        check("wrap_full", {31'd0, full}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'h00);
            check($sformatf("wrapB%0d_rdata", i), {24'd0, rdata}, 32'(8'hA0 + i));
        end
        check("wrap_empty", {31'd0, empty}, 32'd1);

        // Simultaneous push+pop at 8 words: occupancy steady, order preserved.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h30 + i));
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 1'b1, 8'(8'h38 + i));
            check($sformatf("sim%0d_rdata", i), {24'd0, rdata}, 32'(8'h30 + i));
            check_model($sformatf("sim%0d", i));
        end

        // Push+pop while full: pop wins, pushed word dropped.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 8'(8'hC0 + i));
        check("simfull_pre_full", {31'd0, full}, 32'd1);
        step(1'b0, 1'b1, 1'b1, 8'hEE);
        check("simfull_full", {31'd0, full}, 32'd0);
        check("simfull_rdata", {24'd0, rdata}, 32'h44);
        check_model("simfull");
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'h00);
            check_model($sformatf("simfull_drain%0d", i));
        end
        check("simfull_dropped", {24'd0, rdata}, 32'hC7);

        // Push+pop while empty: word stored, rdata unchanged, no fall-through.
        step(1'b0, 1'b1, 1'b1, 8'h5A);
        check("simempty_rdata", {24'd0, rdata}, 32'hC7);
        check("simempty_empty", {31'd0, empty}, 32'd0);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        check("simempty_pop", {24'd0, rdata}, 32'h5A);

        // Reset mid-operation with 5 words stored.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h70 + i));
        step(1'b1, 1'b0, 1'b0, 8'h00);
        check("midrst_empty", {31'd0, empty}, 32'd1);
        check("midrst_rdata", {24'd0, rdata}, 32'd0);
        step(1'b0, 1'b1, 1'b0, 8'h55);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        check("midrst_pop", {24'd0, rdata}, 32'h55);
        check_model("midrst");

        // Randomized traffic with phases biased toward filling and draining.
        for (int i = 0; i < 600; i++) begin
            int pp;
            int pq;
            logic r;
            pp = ((i / 100) % 2 == 0) ? 75 : 30;
            pq = ((i / 100) % 2 == 0) ? 30 : 75;
            r  = ($urandom_range(0, 99) == 0);
            step(r, ($urandom_range(0, 99) < pp), ($urandom_range(0, 99) < pq), 8'($urandom));
            check_model($sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/async_fifo.md
Name: async_fifo

Overview:
- Synchronous-interface FIFO buffer, DEPTH entries of DWIDTH bits.
- Producer side is push/wdata/full; consumer side is pop/rdata/empty.
- Both sides run on one shared clock in this revision.
- Sits between a data producer and a data consumer as an elastic buffer; pointer/flag structure kept compatible with a later dual-clock variant.

Parameters:
- DEPTH, 16, number of storage entries; must equal 2**PTRWIDTH.
- PTRWIDTH, 4, address width of the storage array.
- DWIDTH, 8, data word width in bits.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- push  input  1  write request.
- wdata  input  DWIDTH  write data, sampled on an accepted push.
- full  output  1  FIFO holds DEPTH words.
- pop  input  1  read request.
- rdata  output  DWIDTH  read data, registered.
- empty  output  1  FIFO holds 0 words.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, reset).
- Reset (reset=1 at rising edge): wptr=0, rptr=0, rdata=0, empty=1, full=0. Storage contents are not cleared. Reset has priority over push/pop in the same cycle; a reset mid-operation discards all stored words.
- Pointers: wptr and rptr are PTRWIDTH+1 bits wide. The low PTRWIDTH bits address storage. The MSB is a wrap bit; pointers wrap naturally modulo 2*DEPTH.
- empty = (wptr == rptr).
- full = (MSBs differ) and (low PTRWIDTH bits equal).
- Both flags are decoded from registered pointers, so they change the cycle after the causing edge.
- Push accepted when push=1 and full=0: mem[wptr low bits] <= wdata; wptr increments. Push while full is ignored: no write, no pointer change.
- Pop accepted when pop=1 and empty=0: rdata <= mem[rptr low bits]; rptr increments. Read latency is 1 cycle: data is valid after the edge that accepts the pop. Pop while empty is ignored and rdata holds its previous value.
- rdata holds its value whenever no pop is accepted.
- Simultaneous push+pop, neither flag set: both accepted; occupancy unchanged.
- Simultaneous push+pop while full: pop accepted, push rejected. The push is decided on the pre-edge full flag.
- Simultaneous push+pop while empty: push accepted, pop rejected. No fall-through; the word can be popped on the following cycle at the earliest.
- Order is strict FIFO: words are read in the exact order accepted.
- push and pop are level requests; each accepted cycle transfers exactly one word.

Optional Feature:
- Macro: ASYNC_FIFO_ERR_FLAGS_EN.
- When defined, two extra outputs, both cleared by reset:
  - overflow (1 bit): sticky; sets on the cycle after a push is attempted while full.
  - underflow (1 bit): sticky; sets on the cycle after a pop is attempted while empty.
- When undefined, these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Reset: assert reset for 2 cycles with push=1 → empty=1, full=0, rdata=0; nothing stored afterward.
- Fill: push 0x01..0x10 on 16 consecutive cycles → full=1 the cycle after the 16th push, empty=0. A 17th push with 0xFF is ignored; with ASYNC_FIFO_ERR_FLAGS_EN, overflow=1.
- Drain: pop 16 times → rdata sequence 0x01..0x10, each 1 cycle after its pop. empty=1 after the last. An extra pop leaves rdata=0x10; underflow=1 if enabled.
- Wrap-around: push 10 words, pop 10, then push 16 words (0xA0..0xAF) → full=1; pops return 0xA0..0xAF in order, exercising the pointer MSB wrap.
- Simultaneous: at 8 words, push+pop together for 20 cycles → occupancy stays 8, full=0, empty=0, data stays in order. When full, push+pop → pop succeeds, pushed word dropped. When empty, push+pop → word stored, rdata unchanged.
- Reset mid-operation: with 5 words stored, assert reset → next cycle empty=1; a subsequent push 0x55 then pop returns 0x55.
